tank_hit_accumulator: RTL and testbench

- Per-frame pixel-overlap accumulator for the VGA draw pipeline.
- Counts pixels where a bullet sprite and a tank sprite are both drawn during the active frame.
- At frame end, compares the count against a threshold and commits a 1-bit hit flag.
- Sits directly upstream of the 1-bit read-only PIO input port: accum_flag drives that port's in_port, so the NIOS polls a stable, frame-qualified level once per frame.

---
 rtl/tank_hit_accumulator_pkg.sv | 27 ++
 rtl/tank_hit_accumulator_if.sv | 28 ++
 rtl/tank_hit_accumulator_sat_counter.sv | 35 +++
 rtl/tank_hit_accumulator.sv | 120 ++++++++++++
 tb/tb_tank_hit_accumulator.sv | 342 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tank_hit_accumulator_pkg.sv
// Shared game-pipeline package for the per-frame sprite-overlap stages.
//   - FSM state encoding used by the hit accumulator (2-bit, fixed values)
//   - default counter width and hit threshold
//   - frame strobe bundle reused by other per-frame pipeline stages
//   - hit_pixel(): overlap qualifier for one pixel
package tank_hit_accumulator_pkg;

   localparam int unsigned DefCntW   = 16;
   localparam int unsigned DefThresh = 4;

   // Fixed encoding so software and older pipeline stages see stable values.
   typedef logic [1:0] state_t;
   localparam state_t StIdle   = 2'b00;
   localparam state_t StAccum  = 2'b01;
   localparam state_t StCommit = 2'b10;

   typedef struct packed {
      logic frame_start;
      logic frame_end;
      logic pixel_valid;
   } frame_strobe_t;

   function automatic logic hit_pixel(frame_strobe_t strb, logic tank_px, logic bullet_px);
      return strb.pixel_valid & tank_px & bullet_px;
   endfunction

endpackage

// File: rtl/tank_hit_accumulator_if.sv
// Strobe/result bundle between the VGA draw pipeline and the hit accumulator.
//   master : pipeline side, drives enable and pixel/frame strobes, reads results
//   slave  : accumulator side, consumes strobes, drives accum_flag, hit_count,
//            busy and overrun
interface tank_hit_accumulator_if #(
   parameter int unsigned CNT_W = 16
);
   logic             enable;
   logic             frame_start;
   logic             frame_end;
   logic             pixel_valid;
   logic             tank_px;
   logic             bullet_px;
   logic             accum_flag;
   logic [CNT_W-1:0] hit_count;
   logic             busy;
   logic             overrun;

   modport master (
      output enable, frame_start, frame_end, pixel_valid, tank_px, bullet_px,
      input  accum_flag, hit_count, busy, overrun
   );

   modport slave (
      input  enable, frame_start, frame_end, pixel_valid, tank_px, bullet_px,
      output accum_flag, hit_count, busy, overrun
   );
endinterface

// File: rtl/tank_hit_accumulator_sat_counter.sv
// Saturating up-counter.
//   clk, reset : clock, asynchronous active-high reset (count -> 0)
//   clear      : restart the count; an inc in the same cycle is kept (loads 1)
//   inc        : add one, holding at all-ones instead of wrapping
//   count      : current value
module tank_hit_accumulator_sat_counter #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   logic [WIDTH-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d    = '0;
         count_d[0] = inc;
      end else if (inc && (count_q != '1)) begin
         count_d = count_q + WIDTH'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) count_q <= '0;
      else       count_q <= count_d;
   end

   assign count = count_q;

endmodule

// File: rtl/tank_hit_accumulator.sv
// Per-frame bullet/tank pixel-overlap accumulator. Counts overlapping pixels
// during the active frame and, one cycle after frame end, commits the count and
// a thresholded hit flag. accum_flag feeds the read-only PIO in_port.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : slave side of tank_hit_accumulator_if
//                (enable, frame/pixel strobes in; accum_flag, hit_count, busy,
//                overrun out, all registered)
module tank_hit_accumulator
   import tank_hit_accumulator_pkg::*;
#(
   parameter int unsigned CNT_W  = DefCntW,
   parameter int unsigned THRESH = DefThresh
) (
   input logic                   clk,
   input logic                   reset,
   tank_hit_accumulator_if.slave bus
);

   localparam logic [CNT_W-1:0] ThreshC = CNT_W'(THRESH);

   frame_strobe_t    strb;
   logic             hit_px;
   state_t           state_q, state_d;
   logic             pend_q, pend_d;
   logic             flag_q, flag_d;
   logic [CNT_W-1:0] hit_count_q, hit_count_d;
   logic             overrun_q, overrun_d;
   logic             busy_q, busy_d;
   logic             cnt_clr, cnt_inc;
   logic [CNT_W-1:0] count;

   assign strb = '{frame_start: bus.frame_start,
                   frame_end:   bus.frame_end,
                   pixel_valid: bus.pixel_valid};
   assign hit_px = hit_pixel(strb, bus.tank_px, bus.bullet_px);

   tank_hit_accumulator_sat_counter #(
      .WIDTH (CNT_W)
   ) u_counter (
      .clk   (clk),
      .reset (reset),
      .clear (cnt_clr),
      .inc   (cnt_inc),
      .count (count)
   );

   always_comb begin
      state_d     = state_q;
      pend_d      = pend_q;
      flag_d      = flag_q;
      hit_count_d = hit_count_q;
      overrun_d   = overrun_q;
      cnt_clr     = 1'b0;
      cnt_inc     = 1'b0;
      if (!bus.enable) begin
         state_d = StIdle;
         cnt_clr = 1'b1;
         flag_d  = 1'b0;
         pend_d  = 1'b0;
      end else begin
         case (state_q)
            StIdle: begin
               if (strb.frame_start) begin
                  state_d = StAccum;
                  cnt_clr = 1'b1;
               end
            end
            StAccum: begin
               cnt_inc = hit_px;
               if (strb.frame_end) begin
                  state_d = StCommit;
                  pend_d  = strb.frame_start;
               end else if (strb.frame_start) begin
                  // Missing frame_end: restart the count in place, flag it.
                  cnt_clr   = 1'b1;
                  overrun_d = 1'b1;
               end
            end
            StCommit: begin
               hit_count_d = count;
               flag_d      = (count >= ThreshC);
               pend_d      = 1'b0;
               if (pend_q || strb.frame_start) begin
                  state_d = StAccum;
                  cnt_clr = 1'b1;
               end else begin
                  state_d = StIdle;
               end
            end
            default: state_d = StIdle;
         endcase
      end
      // Busy also bridges a commit cycle whose next frame has already started.
      busy_d = (state_d == StAccum) || ((state_d == StCommit) && pend_d);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= StIdle;
         pend_q      <= 1'b0;
         flag_q      <= 1'b0;
         hit_count_q <= '0;
         overrun_q   <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         pend_q      <= pend_d;
         flag_q      <= flag_d;
         hit_count_q <= hit_count_d;
         overrun_q   <= overrun_d;
         busy_q      <= busy_d;
      end
   end

   assign bus.accum_flag = flag_q;
   assign bus.hit_count  = hit_count_q;
   assign bus.busy       = busy_q;
   assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_tank_hit_accumulator.sv
// Bench for tank_hit_accumulator: two instances (16-bit and 4-bit counters,
// threshold 4) driven by identical strobes. Directed tasks check literal
// values; the random task checks every cycle against a frame-level model.
module tb_tank_hit_accumulator;

   localparam int unsigned T   = 4;
   localparam int unsigned W16 = 16;
   localparam int unsigned W4  = 4;

   logic clk;
   logic reset;
   logic en, fs, fe, pv, tk, bl;

   int vectors;
   int miscompares;

   tank_hit_accumulator_if #(.CNT_W(W16)) if16 ();
   tank_hit_accumulator_if #(.CNT_W(W4))  if4 ();

   assign if16.enable = en;  assign if4.enable = en;
   assign if16.frame_start = fs;  assign if4.frame_start = fs;
   assign if16.frame_end = fe;  assign if4.frame_end = fe;
   assign if16.pixel_valid = pv;  assign if4.pixel_valid = pv;
   assign if16.tank_px = tk;  assign if4.tank_px = tk;
   assign if16.bullet_px = bl;  assign if4.bullet_px = bl;

   tank_hit_accumulator #(.CNT_W(W16), .THRESH(T)) dut16 (
      .clk   (clk),
      .reset (reset),
      .bus   (if16.slave)
   );

   tank_hit_accumulator #(.CNT_W(W4), .THRESH(T)) dut4 (
      .clk   (clk),
      .reset (reset),
      .bus   (if4.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      assert (T <= (1 << W4) - 1) else begin
         $display("FAIL thresh_legal: THRESH %0d exceeds counter range", T);
         $fatal(1, "illegal THRESH");
      end
   end

   // Frame-level model: is a frame open, is a commit due next cycle, did the
   // next frame already start, and the raw (unbounded) overlap count.
   bit m_open, m_cpend, m_restart, m_ovr, m_flag16, m_flag4;
   int m_cnt, m_hc16, m_hc4;

   function automatic int sat(int v, int w);
      int mx = (1 << w) - 1;
      return (v > mx) ? mx : v;
   endfunction

   task automatic model_reset();
      m_open = 0; m_cpend = 0; m_restart = 0; m_ovr = 0;
      m_flag16 = 0; m_flag4 = 0; m_cnt = 0; m_hc16 = 0; m_hc4 = 0;
   endtask

   task automatic model_step();
      int hit = (pv & tk & bl) ? 1 : 0;
      if (!en) begin
         m_open = 0; m_cpend = 0; m_restart = 0; m_cnt = 0;
         m_flag16 = 0; m_flag4 = 0;
      end else if (m_cpend) begin
         m_hc16   = sat(m_cnt, W16);
         m_hc4    = sat(m_cnt, W4);
         m_flag16 = (m_hc16 >= T);
         m_flag4  = (m_hc4 >= T);
         m_cpend  = 0;
         if (m_restart || fs) begin
            m_open = 1;
            m_cnt  = 0;
         end
         m_restart = 0;
      end else if (m_open) begin
         if (fe) begin
            m_cnt += hit; m_open = 0; m_cpend = 1; m_restart = fs;
         end else if (fs) begin
            m_cnt = hit; m_ovr = 1;
         end else begin
            m_cnt += hit;
         end
      end else if (fs) begin
         m_open = 1;
         m_cnt  = 0;
      end
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic cyc(input bit s, input bit e, input bit h);
      fs = s; fe = e; pv = h; tk = h; bl = h;
      tick();
   endtask

   task automatic test_reset();
      reset = 1'b1; en = 0; fs = 0; fe = 0; pv = 0; tk = 0; bl = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      vectors++;
      if ({if16.accum_flag, if16.hit_count, if16.busy, if16.overrun} !== 19'd0) begin
         miscompares++;
         $display("FAIL reset16: got %h want 0",
                  {if16.accum_flag, if16.hit_count, if16.busy, if16.overrun});
      end
      vectors++;
      if ({if4.accum_flag, if4.hit_count, if4.busy, if4.overrun} !== 7'd0) begin
         miscompares++;
         $display("FAIL reset4: got %h want 0",
                  {if4.accum_flag, if4.hit_count, if4.busy, if4.overrun});
      end
      reset = 1'b0;
      en = 1'b1;
   endtask

   task automatic test_low_hits();
      cyc(1, 0, 0);
      repeat (3) cyc(0, 0, 1);
      cyc(0, 1, 0);
      vectors++;
      if (if16.hit_count !== 16'd0) begin
         miscompares++;
         $display("FAIL low_latency: got %0d want 0", if16.hit_count);
      end
      cyc(0, 0, 0);
      vectors++;
      if ({if16.accum_flag, if16.hit_count, if16.busy} !== {1'b0, 16'd3, 1'b0}) begin
         miscompares++;
         $display("FAIL low_hits: got flag=%0b cnt=%0d busy=%0b want 0/3/0",
                  if16.accum_flag, if16.hit_count, if16.busy);
      end
   endtask

   task automatic test_threshold();
      cyc(1, 0, 0);
      repeat (3) cyc(0, 0, 1);
      cyc(0, 1, 1);
      cyc(0, 0, 0);
      vectors++;
      if ({if16.accum_flag, if16.hit_count} !== {1'b1, 16'd4}) begin
         miscompares++;
         $display("FAIL thresh_hit: got flag=%0b cnt=%0d want 1/4",
                  if16.accum_flag, if16.hit_count);
      end
      vectors++;
      if ({if4.accum_flag, if4.hit_count} !== {1'b1, 4'd4}) begin
         miscompares++;
         $display("FAIL thresh_hit4: got flag=%0b cnt=%0d want 1/4",
                  if4.accum_flag, if4.hit_count);
      end
      cyc(1, 0, 0);
      cyc(0, 1, 0);
      cyc(0, 0, 0);
      vectors++;
      if ({if16.accum_flag, if16.hit_count} !== {1'b0, 16'd0}) begin
         miscompares++;
         $display("FAIL thresh_zero: got flag=%0b cnt=%0d want 0/0",
                  if16.accum_flag, if16.hit_count);
      end
   endtask

   task automatic test_saturate();
      cyc(1, 0, 0);
      repeat (20) cyc(0, 0, 1);
      cyc(0, 1, 0);
      cyc(0, 0, 0);
      vectors++;
      if ({if4.accum_flag, if4.hit_count} !== {1'b1, 4'd15}) begin
         miscompares++;
         $display("FAIL saturate4: got flag=%0b cnt=%0d want 1/15",
                  if4.accum_flag, if4.hit_count);
      end
      vectors++;
      if ({if16.accum_flag, if16.hit_count} !== {1'b1, 16'd20}) begin
         miscompares++;
         $display("FAIL saturate16: got flag=%0b cnt=%0d want 1/20",
                  if16.accum_flag, if16.hit_count);
      end
   endtask

   task automatic test_back_to_back();
      cyc(1, 0, 0);
      repeat (6) cyc(0, 0, 1);
      cyc(1, 1, 0);
      vectors++;
      if (if16.busy !== 1'b1) begin
         miscompares++;
         $display("FAIL b2b_busy_commit: got %0b want 1", if16.busy);
      end
      cyc(0, 0, 0);
      vectors++;
      if ({if16.accum_flag, if16.hit_count, if16.busy} !== {1'b1, 16'd6, 1'b1}) begin
         miscompares++;
         $display("FAIL b2b_commit: got flag=%0b cnt=%0d busy=%0b want 1/6/1",
                  if16.accum_flag, if16.hit_count, if16.busy);
      end
      cyc(0, 1, 0);
      cyc(0, 0, 0);
      vectors++;
      if ({if16.accum_flag, if16.hit_count, if16.busy} !== {1'b0, 16'd0, 1'b0}) begin
         miscompares++;
         $display("FAIL b2b_next: got flag=%0b cnt=%0d busy=%0b want 0/0/0",
                  if16.accum_flag, if16.hit_count, if16.busy);
      end
   endtask

   task automatic test_overrun();
      cyc(1, 0, 0);
      repeat (5) cyc(0, 0, 1);
      cyc(1, 0, 0);
      vectors++;
      if ({if16.overrun, if16.busy} !== 2'b11) begin
         miscompares++;
         $display("FAIL overrun_set: got ovr=%0b busy=%0b want 1/1", if16.overrun, if16.busy);
      end
      repeat (2) cyc(0, 0, 1);
      cyc(0, 1, 0);
      cyc(0, 0, 0);
      vectors++;
      if ({if16.accum_flag, if16.hit_count, if16.overrun} !== {1'b0, 16'd2, 1'b1}) begin
         miscompares++;
         $display("FAIL overrun_frame: got flag=%0b cnt=%0d ovr=%0b want 0/2/1",
                  if16.accum_flag, if16.hit_count, if16.overrun);
      end
   endtask

   task automatic test_reset_mid();
      cyc(1, 0, 0);
      repeat (7) cyc(0, 0, 1);
      fs = 0; fe = 0; pv = 0; tk = 0; bl = 0;
      #2 reset = 1'b1;
      #1;
      vectors++;
      if ({if16.accum_flag, if16.hit_count, if16.busy, if16.overrun} !== 19'd0) begin
         miscompares++;
         $display("FAIL reset_mid_async: got %h want 0",
                  {if16.accum_flag, if16.hit_count, if16.busy, if16.overrun});
      end
      model_reset();
      @(posedge clk);
      #1 reset = 1'b0;
      cyc(0, 1, 0);
      cyc(0, 0, 0);
      cyc(0, 0, 0);
      vectors++;
      if ({if16.accum_flag, if16.hit_count, if16.busy} !== {1'b0, 16'd0, 1'b0}) begin
         miscompares++;
         $display("FAIL reset_mid_fe: got flag=%0b cnt=%0d busy=%0b want 0/0/0",
                  if16.accum_flag, if16.hit_count, if16.busy);
      end
   endtask

   task automatic test_enable();
      cyc(1, 0, 0);
      repeat (5) cyc(0, 0, 1);
      cyc(0, 1, 0);
      cyc(0, 0, 0);
      vectors++;
      if ({if16.accum_flag, if16.hit_count} !== {1'b1, 16'd5}) begin
         miscompares++;
         $display("FAIL enable_pre: got flag=%0b cnt=%0d want 1/5",
                  if16.accum_flag, if16.hit_count);
      end
      en = 1'b0;
      cyc(0, 0, 0);
      vectors++;
      if ({if16.accum_flag, if16.hit_count} !== {1'b0, 16'd5}) begin
         miscompares++;
         $display("FAIL enable_off: got flag=%0b cnt=%0d want 0/5",
                  if16.accum_flag, if16.hit_count);
      end
      cyc(1, 0, 1);
      en = 1'b1;
      repeat (2) cyc(0, 0, 1);
      cyc(0, 1, 0);
      cyc(0, 0, 0);
      cyc(0, 0, 0);
      vectors++;
      if ({if16.accum_flag, if16.hit_count, if16.busy} !== {1'b0, 16'd5, 1'b0}) begin
         miscompares++;
         $display("FAIL enable_restart: got flag=%0b cnt=%0d busy=%0b want 0/5/0",
                  if16.accum_flag, if16.hit_count, if16.busy);
      end
   endtask

   task automatic test_random();
      logic [18:0] exp16;
      logic [6:0]  exp4;
      bit          eb;
      for (int i = 0; i < 3000; i++) begin
         en = ($urandom_range(0, 63) != 0);
         fs = ($urandom_range(0, 15) == 0);
         fe = ($urandom_range(0, 15) == 0);
         pv = ($urandom_range(0, 3) != 0);
         tk = ($urandom_range(0, 3) != 0);
         bl = ($urandom_range(0, 3) != 0);
         tick();
         eb    = m_open || (m_cpend && m_restart);
         exp16 = {m_flag16, 16'(m_hc16), eb, m_ovr};
         exp4  = {m_flag4, 4'(m_hc4), eb, m_ovr};
         vectors++;
         if ({if16.accum_flag, if16.hit_count, if16.busy, if16.overrun} !== exp16) begin
            miscompares++;
            $display("FAIL rand16 cyc %0d: got %h want %h", i,
                     {if16.accum_flag, if16.hit_count, if16.busy, if16.overrun}, exp16);
         end
         vectors++;
         if ({if4.accum_flag, if4.hit_count, if4.busy, if4.overrun} !== exp4) begin
            miscompares++;
            $display("FAIL rand4 cyc %0d: got %h want %h", i,
                     {if4.accum_flag, if4.hit_count, if4.busy, if4.overrun}, exp4);
         end
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      test_reset();
      test_low_hits();
      test_threshold();
      test_saturate();
      test_back_to_back();
      test_overrun();
      test_reset_mid();
      test_enable();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
